// File: rtl/multi_magic_tracker_if.sv
// Bundles the per-channel push/pop strobes, capture/clear controls and tracker status.
// master drives the strobes and controls; slave is the tracker that reports status.
interface multi_magic_tracker_if #(
  parameter int NCH    = 4,
  parameter int CNTWID = 4,
  parameter int CHW    = 2
);
  logic [NCH-1:0]        push;
  logic [NCH-1:0]        pop;
  logic                  capture;
  logic [CHW-1:0]        cap_ch;
  logic                  clear;
  logic [NCH*CNTWID-1:0] occ;
  logic [CNTWID-1:0]     pos;
  logic [CHW-1:0]        trk_ch;
  logic                  tracking;
  logic                  done;
  logic                  exit;
  logic [1:0]            err;

  modport master (
    output push, pop, capture, cap_ch, clear,
    input  occ, pos, trk_ch, tracking, done, exit, err
  );

  modport slave (
    input  push, pop, capture, cap_ch, clear,
    output occ, pos, trk_ch, tracking, done, exit, err
  );
endinterface

// File: rtl/multi_magic_tracker.sv
// Per-channel FIFO occupancy counters that follow one tagged packet to the head of its channel.
// Latency: occ/pos/state update on the next edge; exit is combinational in the popping cycle.
// Backpressure: none; pushes into full and pops from empty channels are dropped and flagged in err.
module multi_magic_tracker #(
  parameter int DEPTH  = 8,
  parameter int NCH    = 4,
  parameter int CNTWID = $clog2(DEPTH) + 1,
  parameter int CHW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  multi_magic_tracker_if.slave bus
);
  typedef enum logic [1:0] {IDLE, TRACK, DONE} state_t;

  localparam logic [CNTWID-1:0] FULL = CNTWID'(DEPTH);
  localparam logic [CNTWID-1:0] ONE  = CNTWID'(1);

  state_t            state;
  logic [CNTWID-1:0] occ_q  [NCH];
  logic [CNTWID-1:0] occ_ap [NCH];
  logic [CNTWID-1:0] occ_nx [NCH];
  logic [NCH-1:0]    eff_push;
  logic [NCH-1:0]    eff_pop;
  logic              ovf;
  logic              unf;
  logic              cap_hit;
  logic [CNTWID-1:0] cap_pos;
  logic              trk_pop;
  logic [CNTWID-1:0] pos_q;
  logic [CHW-1:0]    trk_ch_q;
  logic [1:0]        err_q;

  // Pop is qualified against the post-push count so a same-cycle push can feed a pop.
  always_comb begin
    ovf     = 1'b0;
    unf     = 1'b0;
    cap_hit = 1'b0;
    cap_pos = '0;
    trk_pop = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      eff_push[c] = bus.push[c] & (occ_q[c] != FULL);
      occ_ap[c]   = occ_q[c] + CNTWID'(eff_push[c]);
      eff_pop[c]  = bus.pop[c] & (occ_ap[c] != '0);
      occ_nx[c]   = occ_ap[c] - CNTWID'(eff_pop[c]);
      ovf         = ovf | (bus.push[c] & (occ_q[c] == FULL));
      unf         = unf | (bus.pop[c] & (occ_ap[c] == '0));
      // Out-of-range cap_ch matches no channel, so such captures fall through.
      if (bus.cap_ch == CHW'(c)) begin
        cap_hit = bus.capture & eff_push[c];
        cap_pos = occ_nx[c];
      end
      if (trk_ch_q == CHW'(c)) begin
        trk_pop = eff_pop[c];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < NCH; c++) begin
        occ_q[c] <= '0;
      end
      state    <= IDLE;
      pos_q    <= '0;
      trk_ch_q <= '0;
      err_q    <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        occ_q[c] <= occ_nx[c];
      end
      err_q <= err_q | {unf, ovf};
      case (state)
        IDLE: begin
          if (cap_hit) begin
            state    <= TRACK;
            pos_q    <= cap_pos;
            trk_ch_q <= bus.cap_ch;
          end
        end
        TRACK: begin
          if (trk_pop) begin
            if (pos_q == ONE) begin
              state <= DONE;
              pos_q <= '0;
            end else begin
              pos_q <= pos_q - ONE;
            end
          end
        end
        DONE: begin
          if (bus.clear) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.occ = '0;
    for (int c = 0; c < NCH; c++) begin
      bus.occ[c*CNTWID +: CNTWID] = occ_q[c];
    end
  end

  assign bus.pos      = pos_q;
  assign bus.trk_ch   = trk_ch_q;
  assign bus.tracking = (state == TRACK);
  assign bus.done     = (state == DONE);
  assign bus.exit     = (state == TRACK) & trk_pop & (pos_q == ONE);
  assign bus.err      = err_q;
endmodule
